// File: rtl/input_conditioner.sv
// input_conditioner: per-channel 2-FF synchroniser followed by a counter
// debouncer, producing a registered clean level and one-cycle rise/fall
// strobes, all in the pixel clock domain.
// Optional macro INPUT_CONDITIONER_AUTOREPEAT_EN adds auto-repeat of o_rise
// on channels 0-3 while the level is held high.
module input_conditioner #(
    parameter int unsigned N_INPUTS        = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 251750,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned REPEAT_DELAY    = 12587500,
    parameter int unsigned REPEAT_PERIOD   = 3146875
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] i_raw,
    output logic [N_INPUTS-1:0] o_level,
    output logic [N_INPUTS-1:0] o_rise,
    output logic [N_INPUTS-1:0] o_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 || CNT_W > 62 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("input_conditioner: illegal parameter combination");
    end

    logic [N_INPUTS-1:0] sync1;
    logic [N_INPUTS-1:0] sync2;
    logic [CNT_W-1:0]    cnt [N_INPUTS];
    logic [N_INPUTS-1:0] differ;
    logic [N_INPUTS-1:0] commit;
    logic [N_INPUTS-1:0] deb_rise;
    logic [N_INPUTS-1:0] deb_fall;
    logic [N_INPUTS-1:0] rpt_fire;

    // Two-stage synchroniser for the asynchronous pin levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_raw;
            sync2 <= sync1;
        end
    end

    // Decide which channels commit a new level on this edge.
    always_comb begin
        differ   = sync2 ^ o_level;
        commit   = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            commit[i] = differ[i] && (cnt[i] == CNT_LAST);
        end
        deb_rise = commit & sync2;
        deb_fall = commit & ~sync2;
    end

    // Debounce counters and the clean level; any agreeing cycle restarts the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                cnt[i] <= '0;
            end
            o_level <= '0;
        end else begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                if (!differ[i] || commit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            o_level <= o_level ^ commit;
        end
    end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned N_RPT   = (N_INPUTS < 4) ? N_INPUTS : 4;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt [N_RPT];
    logic [N_RPT-1:0] rpt_phase;
    logic [N_RPT-1:0] rpt_hit;

    // Repeat strobe: initial delay first (phase 0), then the shorter period.
    // A falling commit suppresses the repeat so rise and fall never coincide.
    always_comb begin
        rpt_fire = '0;
        rpt_hit  = '0;
        for (int unsigned i = 0; i < N_RPT; i++) begin
            rpt_hit[i]  = rpt_phase[i] ? (rpt[i] == RPT_W'(REPEAT_PERIOD - 1))
                                       : (rpt[i] == RPT_W'(REPEAT_DELAY - 1));
            rpt_fire[i] = o_level[i] && !commit[i] && rpt_hit[i];
        end
    end

    // Repeat counters run only while the clean level is held high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_RPT; i++) begin
                rpt[i] <= '0;
            end
            rpt_phase <= '0;
        end else begin
            for (int unsigned i = 0; i < N_RPT; i++) begin
                if (!o_level[i] || commit[i]) begin
                    rpt[i]       <= '0;
                    rpt_phase[i] <= 1'b0;
                end else if (rpt_hit[i]) begin
                    rpt[i]       <= '0;
                    rpt_phase[i] <= 1'b1;
                end else begin
                    rpt[i]       <= rpt[i] + RPT_W'(1);
                end
            end
        end
    end
`else
    // No auto-repeat: o_rise comes only from debounced presses.
    always_comb begin
        rpt_fire = '0;
    end
`endif

    // Registered one-cycle strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rise <= '0;
            o_fall <= '0;
        end else begin
            o_rise <= deb_rise | rpt_fire;
            o_fall <= deb_fall;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a strobe-event scoreboard.
// Stimulus pushes expected strobe events (edge number, rise, fall, level);
// an independent monitor pops and compares whenever a strobe appears.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] i_raw;
    logic [5:0] o_level;
    logic [5:0] o_rise;
    logic [5:0] o_fall;

    input_conditioner #(
        .N_INPUTS        (6),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (i_raw),
        .o_level (o_level),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         edge_n;
        logic [5:0] rise;
        logic [5:0] fall;
        logic [5:0] level;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp_v, edge_cnt);
    endtask

    // Advance n clock edges, landing 2 time units after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Expect a strobe event 'after' edges from now.
    task automatic expect_ev(input int after, input logic [5:0] r, input logic [5:0] f,
                             input logic [5:0] l);
        ev_t e;
        e.edge_n = edge_cnt + after;
        e.rise   = r;
        e.fall   = f;
        e.level  = l;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every strobe against the oldest expected event.
    always begin
        @(posedge clk);
        #1;
        while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
            mon_ev = exp_q.pop_front();
            n_checks++;
            $display("FAIL missed_event: no strobe at edge %0d, expected rise %h fall %h level %h",
                     mon_ev.edge_n, mon_ev.rise, mon_ev.fall, mon_ev.level);
        end
        if ((o_rise | o_fall) != 6'h00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: edge %0d rise %h fall %h level %h, expected none",
                         edge_cnt, o_rise, o_fall, o_level);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.edge_n == edge_cnt && o_rise === mon_ev.rise &&
                    o_fall === mon_ev.fall && o_level === mon_ev.level) begin
                    n_pass++;
                end else begin
                    $display("FAIL strobe_event: got edge %0d rise %h fall %h level %h, expected edge %0d rise %h fall %h level %h",
                             edge_cnt, o_rise, o_fall, o_level,
                             mon_ev.edge_n, mon_ev.rise, mon_ev.fall, mon_ev.level);
                end
            end
        end
    end

    initial begin : stim
        int base;

        // 1: inputs high through reset, then release.
        rst_n = 1'b0;
        i_raw = 6'h3F;
        repeat (3) begin
            step(1);
            check6("reset_level", o_level, 6'h00);
            check6("reset_rise",  o_rise,  6'h00);
            check6("reset_fall",  o_fall,  6'h00);
        end
        rst_n = 1'b1;
        expect_ev(6, 6'h3F, 6'h00, 6'h3F);
        step(8);
        i_raw = 6'h00;
        expect_ev(6, 6'h00, 6'h3F, 6'h00);
        step(8);

        // 2: single press and release on bit 0.
        i_raw = 6'h01;
        expect_ev(6, 6'h01, 6'h00, 6'h01);
        step(8);
        i_raw = 6'h00;
        expect_ev(6, 6'h00, 6'h01, 6'h00);
        step(8);

        // 3: pulse one cycle short of the debounce window on bit 2.
        i_raw = 6'h04;
        step(3);
        i_raw = 6'h00;
        step(20);
        check6("glitch_level", o_level, 6'h00);

        // 4: bouncing bit 1, window restarts at the last 0->1.
        i_raw = 6'h02; step(1);
        i_raw = 6'h00; step(1);
        i_raw = 6'h02; step(2);
        i_raw = 6'h00; step(1);
        i_raw = 6'h02;
        expect_ev(6, 6'h02, 6'h00, 6'h02);
        step(8);
        i_raw = 6'h00;
        expect_ev(6, 6'h00, 6'h02, 6'h00);
        step(8);

        // 5: bit 3 rises while bit 4 falls on the same edge.
        i_raw = 6'h10;
        expect_ev(6, 6'h10, 6'h00, 6'h10);
        step(8);
        i_raw = 6'h08;
        expect_ev(6, 6'h08, 6'h10, 6'h08);
        step(8);
        i_raw = 6'h00;
        expect_ev(6, 6'h00, 6'h08, 6'h00);
        step(8);

        // 6: reset mid-count on bit 5.
        i_raw = 6'h20;
        step(3);
        rst_n = 1'b0;
        step(1);
        check6("midreset_level", o_level, 6'h00);
        check6("midreset_rise",  o_rise,  6'h00);
        rst_n = 1'b1;
        expect_ev(6, 6'h20, 6'h00, 6'h20);
        step(8);
        i_raw = 6'h00;
        expect_ev(6, 6'h00, 6'h20, 6'h00);
        step(8);

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        // Auto-repeat on bit 0: press, +10, then every +5 until release.
        base  = edge_cnt;
        i_raw = 6'h01;
        expect_ev(6,  6'h01, 6'h00, 6'h01);
        expect_ev(16, 6'h01, 6'h00, 6'h01);
        expect_ev(21, 6'h01, 6'h00, 6'h01);
        expect_ev(26, 6'h01, 6'h00, 6'h01);
        expect_ev(31, 6'h01, 6'h00, 6'h01);
        step(27);
        i_raw = 6'h00;
        expect_ev(6, 6'h00, 6'h01, 6'h00);
        step(10);
        if (edge_cnt - base != 37) $display("note: autorepeat sequence length %0d edges", edge_cnt - base);
`else
        base = edge_cnt;
`endif

        step(2);
        while (exp_q.size() > 0) begin
            mon_ev = exp_q.pop_front();
            n_checks++;
            $display("FAIL leftover_event: edge %0d rise %h fall %h level %h never seen",
                     mon_ev.edge_n, mon_ev.rise, mon_ev.fall, mon_ev.level);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
